// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared types and address-range helper for the data memory responder
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;

  localparam int STRB_W     = 4;
  localparam int WORD_BYTES = 4;

  // Widened to 64 bits so base + span never wraps for any legal ADDR_WIDTH up to 32.
  function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                    input int unsigned depth);
    logic [63:0] span;
    span = 64'(depth) * 64'(WORD_BYTES);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response channel bundle between memory stage and responder
interface data_mem_responder_if
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic [STRB_W-1:0]     req_wstrb;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/sram_bytewise.sv
// rtl/sram_bytewise.sv - single-port word RAM with byte write enables and registered read
module sram_bytewise #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read data holds between reads so the response stays stable under backpressure.
  always_comb begin
    rdata_d = rdata_q;
    if (en && !we) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding load/store responder backed by an on-chip RAM
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h1c000000,
  parameter int                    WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  data_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    ram_en;
  logic [31:0]             ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    ram_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          idx_d   = bus.req_addr[IDX_W+1:2];
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          err_d   = !in_range(64'(bus.req_addr), 64'(BASE_ADDR), DEPTH_WORDS);
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ACCESS: begin
        // Faulting accesses never touch the RAM, so a stray store cannot corrupt it.
        ram_en  = !err_q;
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  sram_bytewise #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .be    (wstrb_q),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ram_rdata : 32'h0;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the load/store memory interface issued by the memory-access stage. It accepts one request at a time on a valid/ready request channel and performs a byte-strobed word write or a full-word read on an on-chip data RAM. After a programmable number of wait states, it returns a response on a valid/ready response channel. It replaces the simulation-only pmem hook, so the load/store path becomes synthesizable and latency-aware.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width; fixed at 32 (strobe width = 4)
DEPTH_WORDS, 1024, RAM depth in 32-bit words; must be a power of two
BASE_ADDR, 32'h1c000000, byte address of RAM word 0; must be aligned to DEPTH_WORDS*4
WAIT_CYCLES, 2, wait states between request accept and response valid; 0 is legal

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, already lane-shifted by the initiator
req_wstrb  in  4  byte enables for stores; ignored for loads
resp_valid  out  1  response present
resp_ready  in  1  initiator accepts response
resp_rdata  out  32  full aligned word for loads; 0 for stores and errors
resp_err  out  1  access fault

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - Async assert forces state IDLE, wait counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
  - RAM contents are not reset.
  - req_ready reads 1 in the first cycle after deassertion.
- States:
  - IDLE: req_ready=1, resp_valid=0. On req_valid&&req_ready, latch we/addr/wdata/wstrb. Go to WAIT if WAIT_CYCLES>0, else to ACCESS.
  - WAIT: req_ready=0. The counter loads WAIT_CYCLES-1 on entry and decrements each cycle. At 0, go to ACCESS.
  - ACCESS (one cycle): req_ready=0.
    - In-range store: write strobed lanes at word index addr[log2(DEPTH_WORDS)+1:2].
    - Load: issue a synchronous RAM read.
    - Then go to RESP.
  - RESP: resp_valid=1. Outputs are registered and held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE. resp_valid drops the next cycle.
- Latency: with resp_ready tied high, the response handshake completes WAIT_CYCLES+2 cycles after the request handshake. The earliest next request is accepted one cycle later. There is no overlap; one transaction is outstanding at most.
- Addressing: addr[1:0] is ignored for RAM indexing. The initiator does lane select and sign extension. Loads always return the whole word.
- Range: an address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4) gives resp_err=1 and resp_rdata=0, with no RAM write.
- Stores:
  - req_wstrb==0 is legal; it produces no write, resp_err=0, resp_rdata=0.
  - Unwritten lanes keep their prior value.
- Ordering: a load following a store to the same word returns the stored data, since there is no overlap.
- Inputs outside the IDLE handshake are ignored. A request held valid while the responder is busy is accepted on return to IDLE.
- Backpressure: an indefinite resp_ready=0 holds RESP with stable outputs. There is no timeout.
- Reset mid-transaction (WAIT/ACCESS/RESP):
  - The transaction is dropped and no response is issued.
  - A store already committed in ACCESS stays committed; a store reset before ACCESS is not written.

Decomposition:
- Package mem_resp_pkg: state enum (IDLE, WAIT, ACCESS, RESP), STRB_W=4, WORD_BYTES=4, and an in-range helper function (addr, base, depth).
- One sub-module, sram_bytewise: DEPTH_WORDS×32 single-port RAM with 4-bit byte write enable and 1-cycle synchronous read. No reset on storage.

Test Plan:
- Store 32'hdec0de11 at 32'h1c000000, strobe 4'b1111, then load the same address. Expect load rdata 32'hdec0de11, err 0. With WAIT_CYCLES=2, resp_valid rises 4 cycles after each request handshake.
- Preload 32'h00000000 at 32'h1c000004. Then store 32'h00ab0000 with strobe 4'b0100, and store 32'hcd000000 with strobe 4'b1000, both at 32'h1c000006. Load 32'h1c000004 → expect 32'hcdab0000.
- Load 32'h1c001000 (just past 1024 words), and store to 32'h1bfffffc. Both → err 1, rdata 0. A reload of 32'h1c000000 is unchanged.
- Hold resp_ready=0 for 10 cycles during a load response. resp_valid stays 1 and rdata stays stable. req_ready=0 throughout, and a pending req_valid is accepted only after the handshake.
- Assert rst_n=0 in WAIT of a store 32'h12345678 to 32'h1c000010. No response follows; req_ready=1 after release; a load of 32'h1c000010 returns the prior contents.
- WAIT_CYCLES=0 build, back-to-back requests with resp_ready=1 → request handshakes spaced exactly 3 cycles apart.
